// File: rtl/react_keypad.sv
// 4x4 matrix keypad scanner: active-low row drive, synchronized column sense,
// whole-frame debounce, one-cycle key_valid strobe and key_held level.
module react_keypad #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int             CW   = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CMAX = CW'(SCAN_DIV - 1);
  localparam logic [3:0]     DBF  = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  state_t      state, state_n;
  logic [3:0]  s1, s2;
  logic [CW-1:0] cnt;
  logic [1:0]  ridx;
  logic [15:0] snap;
  logic [15:0] frame;
  logic        tick;
  logic        frame_done;
  logic [4:0]  nkeys;
  logic [3:0]  code;
  logic        none;
  logic        single;
  logic        cand_hit;
  logic [3:0]  cand, cand_n;
  logic [3:0]  dbcnt, dbcnt_n;
  logic [3:0]  dbinc;
  logic        valid_n;

  assign tick       = (cnt == CMAX);
  assign frame_done = tick && (ridx == 2'd3);
  assign row        = ~(4'b0001 << ridx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= '0;
      s2   <= '0;
      cnt  <= '0;
      ridx <= '0;
      snap <= '0;
    end else begin
      s1 <= col;
      s2 <= s1;
      if (tick) begin
        cnt                    <= '0;
        ridx                   <= ridx + 2'd1;
        snap[{ridx, 2'b00} +: 4] <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Row 3 is still being sampled on the completing tick, so splice it in.
  always_comb begin
    frame = {~s2, snap[11:0]};
    nkeys = '0;
    code  = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        nkeys = nkeys + 5'd1;
        code  = 4'(i);
      end
    end
  end

  assign none     = (nkeys == 5'd0);
  assign single   = (nkeys == 5'd1);
  assign cand_hit = frame[cand];
  assign dbinc    = (dbcnt < DBF) ? dbcnt + 4'd1 : dbcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cand      <= '0;
      dbcnt     <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      dbcnt     <= dbcnt_n;
      key_valid <= valid_n;
      if (valid_n) key_code <= cand_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    dbcnt_n = dbcnt;
    if (frame_done) begin
      unique case (state)
        IDLE: begin
          if (single) begin
            cand_n  = code;
            dbcnt_n = 4'd1;
            state_n = (DBF <= 4'd1) ? PRESSED : DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (single && code == cand) begin
            dbcnt_n = dbinc;
            if (dbinc >= DBF) state_n = PRESSED;
          end else begin
            state_n = IDLE;
            dbcnt_n = '0;
          end
        end
        PRESSED: begin
          if (!cand_hit) begin
            if (none && DBF <= 4'd1) begin
              state_n = IDLE;
              dbcnt_n = '0;
            end else begin
              state_n = RELEASE;
              dbcnt_n = 4'd1;
            end
          end
        end
        RELEASE: begin
          if (cand_hit) begin
            state_n = PRESSED;
            dbcnt_n = '0;
          end else if (none) begin
            dbcnt_n = dbinc;
            if (dbinc >= DBF) begin
              state_n = IDLE;
              dbcnt_n = '0;
            end
          end else begin
            dbcnt_n = 4'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    valid_n  = frame_done && (state_n == PRESSED) &&
               (state == IDLE || state == DEBOUNCE);
    key_held = (state == PRESSED) || (state == RELEASE);
  end

endmodule

// File: tb/tb_react_keypad.sv
// Directed bench for react_keypad with a 4x4 switch-matrix model;
// SCAN_DIV=4, DEBOUNCE_FRAMES=3, so one frame is 16 cycles.
module tb_react_keypad;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = '0;
  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int cyc    = 0;

  localparam int VBOUND = 4 * 16 + 3;

  react_keypad #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row[r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) col[c] = 1'b0;
  end

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  always @(negedge clk)
    if (key_valid) vcount = vcount + 1;

  task automatic reset_dut();
    @(negedge clk);
    rst  = 1'b0;
    keys = '0;
    repeat (3) @(negedge clk);
    vcount = 0;
    rst = 1'b1;
  endtask

  task automatic wait_boundary();
    do @(negedge clk); while (cyc % 16 != 0);
  endtask

  task automatic wait_valid(input string name, output logic found);
    found = 1'b0;
    for (int n = 0; n < VBOUND && !found; n++) begin
      @(negedge clk);
      if (key_valid) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: key_valid seen=0 required=1 within %0d cycles",
               name, VBOUND);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (row !== 4'b1110) begin
      errors++; $display("FAIL rst_row: got %b want 1110", row);
    end
    checks++;
    if (key_code !== 4'd0) begin
      errors++; $display("FAIL rst_code: got %0d want 0", key_code);
    end
    checks++;
    if (key_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid: got %b want 0", key_valid);
    end
    checks++;
    if (key_held !== 1'b0) begin
      errors++; $display("FAIL rst_held: got %b want 0", key_held);
    end
    reset_dut();
    for (int k = 0; k < 64; k++) begin
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      checks++;
      if (row !== exp_row) begin
        errors++; $display("FAIL row_seq[%0d]: got %b want %b", k, row, exp_row);
      end
      @(negedge clk);
    end
    begin
      int held_hi = 0;
      for (int k = 0; k < 10 * 16; k++) begin
        @(negedge clk);
        if (key_held) held_hi++;
      end
      checks++;
      if (held_hi != 0) begin
        errors++; $display("FAIL idle_held: high cycles=%0d want 0", held_hi);
      end
      #1;
      checks++;
      if (vcount != 0) begin
        errors++; $display("FAIL idle_valid: strobes=%0d want 0", vcount);
      end
    end
  endtask

  task automatic test_press();
    logic found;
    int held_lo = 0;
    reset_dut();
    keys = 16'h0200;
    wait_valid("press9_valid", found);
    checks++;
    if (key_code !== 4'd9) begin
      errors++; $display("FAIL press9_code: got %0d want 9", key_code);
    end
    @(negedge clk);
    checks++;
    if (key_valid !== 1'b0) begin
      errors++; $display("FAIL press9_pulse: valid=%b want 0 next cycle", key_valid);
    end
    for (int k = 0; k < 10 * 16; k++) begin
      if (!key_held) held_lo++;
      @(negedge clk);
    end
    checks++;
    if (held_lo != 0) begin
      errors++; $display("FAIL press9_held: low cycles=%0d want 0", held_lo);
    end
    #1;
    checks++;
    if (vcount != 1) begin
      errors++; $display("FAIL press9_once: strobes=%0d want 1", vcount);
    end
  endtask

  task automatic test_bounce();
    int held_hi = 0;
    reset_dut();
    keys = 16'h0008;
    repeat (16) @(negedge clk);
    keys = 16'h0000;
    repeat (16) @(negedge clk);
    keys = 16'h0008;
    repeat (16) @(negedge clk);
    keys = 16'h0000;
    for (int k = 0; k < 5 * 16; k++) begin
      @(negedge clk);
      if (key_held) held_hi++;
    end
    #1;
    checks++;
    if (vcount != 0) begin
      errors++; $display("FAIL bounce_valid: strobes=%0d want 0", vcount);
    end
    checks++;
    if (held_hi != 0) begin
      errors++; $display("FAIL bounce_held: high cycles=%0d want 0", held_hi);
    end
  endtask

  task automatic test_chord();
    logic found;
    int held_lo = 0;
    reset_dut();
    keys = 16'h0200;
    wait_valid("chord_first_valid", found);
    wait_boundary();
    keys = 16'h0220;
    for (int k = 0; k < 5 * 16; k++) begin
      @(negedge clk);
      if (!key_held) held_lo++;
    end
    checks++;
    if (held_lo != 0) begin
      errors++; $display("FAIL chord_held: low cycles=%0d want 0", held_lo);
    end
    wait_boundary();
    keys = 16'h0000;
    repeat (47) @(negedge clk);
    checks++;
    if (key_held !== 1'b1) begin
      errors++; $display("FAIL chord_rel_early: held=%b want 1", key_held);
    end
    @(negedge clk);
    checks++;
    if (key_held !== 1'b0) begin
      errors++; $display("FAIL chord_rel_drop: held=%b want 0", key_held);
    end
    checks++;
    if (key_code !== 4'd9) begin
      errors++; $display("FAIL chord_code: got %0d want 9", key_code);
    end
    #1;
    checks++;
    if (vcount != 1) begin
      errors++; $display("FAIL chord_once: strobes=%0d want 1", vcount);
    end
  endtask

  task automatic test_back_to_back();
    logic found;
    int held_lo = 0;
    reset_dut();
    keys = 16'h0200;
    wait_valid("repress_first_valid", found);
    wait_boundary();
    keys = 16'h0000;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (!key_held) held_lo++;
    end
    keys = 16'h0200;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (!key_held) held_lo++;
    end
    checks++;
    if (held_lo != 0) begin
      errors++; $display("FAIL repress_held: low cycles=%0d want 0", held_lo);
    end
    #1;
    checks++;
    if (vcount != 1) begin
      errors++; $display("FAIL repress_once: strobes=%0d want 1", vcount);
    end
    wait_boundary();
    keys = 16'h0000;
    repeat (64) @(negedge clk);
    checks++;
    if (key_held !== 1'b0) begin
      errors++; $display("FAIL full_release: held=%b want 0", key_held);
    end
    keys = 16'h8000;
    wait_valid("press15_valid", found);
    checks++;
    if (key_code !== 4'd15) begin
      errors++; $display("FAIL press15_code: got %0d want 15", key_code);
    end
    #1;
    checks++;
    if (vcount != 2) begin
      errors++; $display("FAIL press15_count: strobes=%0d want 2", vcount);
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    reset_dut();
    keys = 16'h0200;
    wait_valid("mid_prev_valid", found);
    wait_boundary();
    keys = 16'h0000;
    repeat (64) @(negedge clk);
    checks++;
    if (key_code !== 4'd9) begin
      errors++; $display("FAIL mid_prev_code: got %0d want 9", key_code);
    end
    keys = 16'h0040;
    repeat (24) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (row !== 4'b1110) begin
      errors++; $display("FAIL mid_rst_row: got %b want 1110", row);
    end
    checks++;
    if (key_code !== 4'd0) begin
      errors++; $display("FAIL mid_rst_code: got %0d want 0", key_code);
    end
    checks++;
    if (key_valid !== 1'b0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_flags: valid=%b held=%b want 0 0", key_valid, key_held);
    end
    @(negedge clk);
    vcount = 0;
    rst = 1'b1;
    wait_valid("mid_key6_valid", found);
    checks++;
    if (key_code !== 4'd6) begin
      errors++; $display("FAIL mid_key6_code: got %0d want 6", key_code);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_chord();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/react_keypad.md
Name: react_keypad

Overview:
- 4x4 matrix keypad scanner for the reaction-tester board; the input-side counterpart of the multiplexed 7-segment driver.
- Drives row lines one at a time (active-low) and samples the column lines.
- Debounces over whole scan frames and emits a one-cycle key_valid strobe with a 4-bit key code.
- Feeds the timer/control logic alongside BTN0.

Parameters:
- SCAN_DIV, 50000, clk cycles each row is driven (1 ms at 50 MHz); minimum 4.
- DEBOUNCE_FRAMES, 4, consecutive identical full frames required to accept a press or a release; range 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- row  output  4  row drive, active-low, exactly one bit low at all times.
- col  input  4  column sense, pulled up externally, low = key closed; asynchronous to clk.
- key_code  output  4  code of the accepted key, row*4+col; holds its value until the next accepted press.
- key_valid  output  1  one-cycle strobe when a press is accepted.
- key_held  output  1  high while the accepted key is still considered down.

Behaviour:

Reset (rst=0, asynchronous):
- row=4'b1110, key_code=0, key_valid=0, key_held=0.
- State IDLE; all counters, synchronizer flops and the frame snapshot cleared.

Column input and row scan:
- col passes through a 2-flop synchronizer before any use.
- Dwell counter counts 0..SCAN_DIV-1. The tick is the cycle where count==SCAN_DIV-1.
- On tick, the synchronized col is stored into the snapshot bits for the current row index r (0..3), then row rotates: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- Row index r is the position of the low bit.
- A frame completes on the tick of row index 3. The 16-bit snapshot is then evaluated as: none pressed, exactly one pressed (code = r*4+c), or multiple pressed.

FSM (advances only on frame-complete; dbcnt is a 4-bit frame counter):
- IDLE:
  - single key -> DEBOUNCE, cand=code, dbcnt=1.
  - none or multiple -> stay.
  - If DEBOUNCE_FRAMES==1, a single key goes directly to PRESSED.
- DEBOUNCE:
  - same single key -> dbcnt+1; when dbcnt reaches DEBOUNCE_FRAMES -> PRESSED.
  - different key, none, or multiple -> IDLE, dbcnt=0.
- PRESSED:
  - On entry, key_code<=cand and key_valid=1 for exactly the one cycle after the frame-complete tick. key_held=1.
  - Frame still contains cand (alone or with other keys) -> stay.
  - Frame without cand -> RELEASE, dbcnt=1.
- RELEASE:
  - no key pressed -> dbcnt+1; when dbcnt reaches DEBOUNCE_FRAMES -> IDLE, key_held=0.
  - cand pressed again -> PRESSED, no new key_valid.
  - other key(s) pressed -> dbcnt restarts at 1.

Timing and boundary rules:
- Latency: key_valid asserts no later than (DEBOUNCE_FRAMES+1)*4*SCAN_DIV+3 cycles after col becomes stable.
- A chord of two or more keys is never accepted as a new press.
- A key held indefinitely produces one key_valid only; there is no auto-repeat.
- The frame snapshot and the row rotation do not depend on FSM state.
- Asserting rst mid-frame or mid-debounce immediately returns all state and outputs to their reset values. The scan restarts at row 0, and the partial frame is discarded.
- Counters never overflow: dbcnt saturates at DEBOUNCE_FRAMES.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3, so 1 frame = 16 cycles):
- Release rst with no key -> row sequence 1110,1101,1011,0111 repeats with a 4-cycle dwell; key_valid and key_held stay 0 for 10 frames.
- Model closes key r=2,c=1 (col[1]=0 whenever row[2]=0) and holds it -> exactly one key_valid with key_code=9, within 4 frames plus 3 cycles. key_held=1 for the whole hold.
- Key r=0,c=3 bounces (present 1 frame, absent 1, present 1, absent) -> no key_valid; FSM returns to IDLE.
- Key 9 accepted, then key 5 added alongside it -> no new key_valid; key_held stays 1. Releasing both -> key_held drops exactly 3 empty frames later; key_code stays 9.
- Key 9 accepted, released for 2 frames, then pressed again -> key_held stays 1 throughout and no second key_valid. Full release followed by a fresh press of key 15 -> key_valid with key_code=15.
- rst pulsed low for 1 cycle during the DEBOUNCE of key 6 -> outputs return to reset values asynchronously and row=1110. If key 6 stays held, a key_valid follows within 4 frames of reset release.
